uart_rx_engine: RTL

Serial receive engine feeding the RX FIFO inside uart_top. It synchronises the rx_i pin and oversamples it with the 8x baud tick from the divide-by-8 clock divider. It deframes start, data, optional parity and stop bits, then presents each byte on a valid/ready interface to the RX FIFO write port. It also flags parity, framing and overrun errors toward the interrupt logic.

---
 rtl/uart_rx_engine.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 8x-oversampled UART receiver with a valid/ready byte port.
// Build option: UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority bit sampling.
module uart_rx_engine #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 enable_i,
  input  logic                 tick_8x_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 two_stop_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             tick_cnt;
  logic [2:0]             cnt_nxt;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_acc;
  logic                   parity_bad;
  logic                   frame_bad;
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   two_stop_q;
  logic                   bit_stb;
  logic                   bit_val;

  // Bring the asynchronous line into the clock domain, idling high.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign cnt_nxt = tick_cnt + 3'd1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q;

  // Hold the count-3 and count-4 samples for the vote at count 5.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      vote_q <= 2'b11;
    end else if (tick_8x_i && state != IDLE) begin
      if (cnt_nxt == 3'd3) vote_q[0] <= rx_s;
      if (cnt_nxt == 3'd4) vote_q[1] <= rx_s;
    end
  end

  assign bit_stb = tick_8x_i && (state != IDLE)
                   && (cnt_nxt == 3'd5);
  assign bit_val = (vote_q[0] & vote_q[1])
                 | (vote_q[0] & rx_s)
                 | (vote_q[1] & rx_s);
`else
  assign bit_stb = tick_8x_i && (state != IDLE)
                   && (cnt_nxt == 3'd4);
  assign bit_val = rx_s;
`endif

  // Frame deserialiser, error tracking and output handshake.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      par_acc      <= 1'b0;
      parity_bad   <= 1'b0;
      frame_bad    <= 1'b0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (tick_8x_i && state != IDLE) tick_cnt <= cnt_nxt;

      if (!enable_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (tick_8x_i && !rx_s) begin
              state      <= START;
              busy_o     <= 1'b1;
              tick_cnt   <= '0;
              bit_cnt    <= '0;
              par_acc    <= 1'b0;
              parity_bad <= 1'b0;
              frame_bad  <= 1'b0;
              par_en_q   <= parity_en_i;
              par_odd_q  <= parity_odd_i;
              two_stop_q <= two_stop_i;
            end
          end
          START: begin
            if (bit_stb) begin
              if (bit_val) begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (bit_stb) begin
              shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
              par_acc <= par_acc ^ bit_val;
              if (bit_cnt == LAST) begin
                bit_cnt <= '0;
                state   <= par_en_q ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          PARITY: begin
            if (bit_stb) begin
              parity_bad <= (par_acc ^ bit_val) != par_odd_q;
              state      <= STOP;
            end
          end
          STOP: begin
            if (bit_stb) begin
              if (two_stop_q && bit_cnt == '0) begin
                bit_cnt   <= bit_cnt + 1'b1;
                frame_bad <= frame_bad | ~bit_val;
              end else begin
                state        <= IDLE;
                busy_o       <= 1'b0;
                parity_err_o <= parity_bad;
                frame_err_o  <= frame_bad | ~bit_val;
                if (!rx_valid_o || rx_ready_i) begin
                  rx_data_o  <= shift_q;
                  rx_valid_o <= 1'b1;
                end else begin
                  overrun_o <= 1'b1;
                end
              end
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
